reg_bank_reader: RTL

//  Banked register-file responder for decode-stage operand reads. Accepts one request of up to three

---
 rtl/reg_bank_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/reg_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_reader
//  Description : Banked register-file responder for decode-stage operand
//                reads. Serialises operands that collide on one bank and
//                owns the writeback write port of the bank storage.
//                Optional macro REG_WR_BYPASS_EN forwards a same-cycle
//                write into the operand being read.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_reader #(
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5,
    parameter int DataWidth    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [TotalNumBank-1:0]         readEn1,
    input  logic [TotalNumBank-1:0]         readEn2,
    input  logic [TotalNumBank-1:0]         readEn3,
    input  logic [AddrWidth-1:0]            readAddr1,
    input  logic [AddrWidth-1:0]            readAddr2,
    input  logic [AddrWidth-1:0]            readAddr3,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DataWidth-1:0]            op1_data,
    output logic [DataWidth-1:0]            op2_data,
    output logic [DataWidth-1:0]            op3_data,
    output logic [1:0]                      read_cycles,
    input  logic                            wr_en,
    input  logic [$clog2(TotalNumBank)-1:0] wr_bank,
    input  logic [AddrWidth-1:0]            wr_addr,
    input  logic [DataWidth-1:0]            wr_data
);

    localparam int BW = $clog2(TotalNumBank);
    localparam logic [BW:0] c_num_bank = (BW+1)'(TotalNumBank);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [DataWidth-1:0] r_mem [TotalNumBank][2**AddrWidth];

    logic [BW-1:0]        r_bank1, r_bank2, r_bank3;
    logic [AddrWidth-1:0] r_addr1, r_addr2, r_addr3;
    logic                 r_pend1, r_pend2, r_pend3;
    logic [DataWidth-1:0] r_op1, r_op2, r_op3;
    logic [1:0]           r_cnt;
    logic [1:0]           r_read_cycles;

    logic                 w_g1, w_g2, w_g3;
    logic                 w_more;
    logic                 w_wr_ok;
    logic [DataWidth-1:0] w_rd1, w_rd2, w_rd3;

    // Lowest set bit of a one-hot (or multi-hot) enable selects the bank
    function automatic logic [BW-1:0] f_low_bank(input logic [TotalNumBank-1:0] en);
        f_low_bank = '0;
        for (int i = TotalNumBank - 1; i >= 0; i--) begin
            if (en[i]) f_low_bank = BW'(i);
        end
    endfunction

    assign w_wr_ok = wr_en && ({1'b0, wr_bank} < c_num_bank);

    // Per-bank grant: op1 beats op2 beats op3 when they share a bank
    always_comb begin
        w_g1   = r_pend1;
        w_g2   = r_pend2 && !(r_pend1 && (r_bank1 == r_bank2));
        w_g3   = r_pend3 && !(r_pend1 && (r_bank1 == r_bank3))
                         && !(r_pend2 && (r_bank2 == r_bank3));
        w_more = (r_pend2 && !w_g2) || (r_pend3 && !w_g3);
    end

    // Combinational storage read, optionally forwarding a colliding write
    always_comb begin
        w_rd1 = r_mem[r_bank1][r_addr1];
        w_rd2 = r_mem[r_bank2][r_addr2];
        w_rd3 = r_mem[r_bank3][r_addr3];
`ifdef REG_WR_BYPASS_EN
        if (w_wr_ok && (wr_bank == r_bank1) && (wr_addr == r_addr1)) w_rd1 = wr_data;
        if (w_wr_ok && (wr_bank == r_bank2) && (wr_addr == r_addr2)) w_rd2 = wr_data;
        if (w_wr_ok && (wr_bank == r_bank3) && (wr_addr == r_addr3)) w_rd3 = wr_data;
`else
        // Reads see the pre-write contents; the new value appears next cycle
`endif
    end

    // Writeback port into bank storage, independent of the FSM, not reset
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[wr_bank][wr_addr] <= wr_data;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_READ;
            S_READ:  if (!w_more)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, operand grants and cycle accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank1       <= '0;
            r_bank2       <= '0;
            r_bank3       <= '0;
            r_addr1       <= '0;
            r_addr2       <= '0;
            r_addr3       <= '0;
            r_pend1       <= 1'b0;
            r_pend2       <= 1'b0;
            r_pend3       <= 1'b0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_op3         <= '0;
            r_cnt         <= 2'd0;
            r_read_cycles <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bank1 <= f_low_bank(readEn1);
                        r_bank2 <= f_low_bank(readEn2);
                        r_bank3 <= f_low_bank(readEn3);
                        r_addr1 <= readAddr1;
                        r_addr2 <= readAddr2;
                        r_addr3 <= readAddr3;
                        r_pend1 <= |readEn1;
                        r_pend2 <= |readEn2;
                        r_pend3 <= |readEn3;
                        r_op1   <= '0;
                        r_op2   <= '0;
                        r_op3   <= '0;
                        r_cnt   <= 2'd0;
                    end
                end
                S_READ: begin
                    if (w_g1) begin
                        r_op1   <= w_rd1;
                        r_pend1 <= 1'b0;
                    end
                    if (w_g2) begin
                        r_op2   <= w_rd2;
                        r_pend2 <= 1'b0;
                    end
                    if (w_g3) begin
                        r_op3   <= w_rd3;
                        r_pend3 <= 1'b0;
                    end
                    r_cnt <= r_cnt + 2'd1;
                    if (!w_more) r_read_cycles <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign op1_data    = r_op1;
    assign op2_data    = r_op2;
    assign op3_data    = r_op3;
    assign read_cycles = r_read_cycles;

endmodule
`default_nettype wire
